// File: rtl/fft8_bin_unloader.sv
// Captures the eight parallel fft8 bins on in_stb and streams them one bin per
// valid/ready beat with an approximate magnitude; one frame can wait in a pending slot.
module fft8_bin_unloader #(
   parameter int DATA_W = 16,
   parameter int DROP_W = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_stb,
   input  logic [8*DATA_W-1:0]   in_real,
   input  logic [8*DATA_W-1:0]   in_imag,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic [DATA_W-1:0]     m_real,
   output logic [DATA_W-1:0]     m_imag,
   output logic [DATA_W-1:0]     m_mag,
   output logic [2:0]            m_index,
   output logic                  m_last,
   output logic                  ovf,
   input  logic                  clr_ovf,
   output logic [DROP_W-1:0]     drop_cnt
);

   // Handshake: a beat transfers on a rising edge where m_valid && m_ready;
   // while m_ready is low every m_* output holds its value.

   typedef enum logic {IDLE = 1'b0, STREAM = 1'b1} state_t;

   state_t                state, state_nxt;
   logic [8*DATA_W-1:0]   act_re, act_im;
   logic [8*DATA_W-1:0]   pend_re, pend_im;
   logic                  pend_valid;
   logic [2:0]            idx;

   logic beat, last_beat, load_in, promote, pend_cap, drop;

   always_comb begin
      beat      = (state == STREAM) && m_ready;
      last_beat = beat && (idx == 3'd7);
      load_in   = in_stb && ((state == IDLE) || (last_beat && !pend_valid));
      promote   = last_beat && pend_valid;
      // On a last beat with the slot full, promotion frees the slot for the new frame.
      pend_cap  = in_stb && (state == STREAM) && (last_beat ? pend_valid : !pend_valid);
      drop      = in_stb && (state == STREAM) && !last_beat && pend_valid;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (in_stb) state_nxt = STREAM;
         STREAM:  if (last_beat && !pend_valid && !in_stb) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      m_valid = (state == STREAM);
      m_index = idx;
      m_last  = (state == STREAM) && (idx == 3'd7);
      m_real  = act_re[idx*DATA_W +: DATA_W];
      m_imag  = act_im[idx*DATA_W +: DATA_W];
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         act_re     <= '0;
         act_im     <= '0;
         pend_re    <= '0;
         pend_im    <= '0;
         pend_valid <= 1'b0;
         idx        <= 3'd0;
      end else begin
         if (load_in) begin
            act_re <= in_real;
            act_im <= in_imag;
         end else if (promote) begin
            act_re <= pend_re;
            act_im <= pend_im;
         end
         if (pend_cap) begin
            pend_re <= in_real;
            pend_im <= in_imag;
         end
         if (pend_cap)     pend_valid <= 1'b1;
         else if (promote) pend_valid <= 1'b0;
         if (last_beat || load_in) idx <= 3'd0;
         else if (beat)            idx <= idx + 3'd1;
      end
   end

   // A drop in the same cycle as clr_ovf wins and restarts the count at one.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ovf      <= 1'b0;
         drop_cnt <= '0;
      end else if (drop) begin
         ovf <= 1'b1;
         if (clr_ovf)              drop_cnt <= DROP_W'(1);
         else if (drop_cnt != '1)  drop_cnt <= drop_cnt + DROP_W'(1);
      end else if (clr_ovf) begin
         ovf      <= 1'b0;
         drop_cnt <= '0;
      end
   end

   // One extra bit so that -32768 has a representable absolute value.
   logic signed [DATA_W:0] re_x, im_x;
   logic        [DATA_W:0] abs_re, abs_im, mag_max, mag_min, mag_sum;

   always_comb begin
      re_x    = {m_real[DATA_W-1], m_real};
      im_x    = {m_imag[DATA_W-1], m_imag};
      abs_re  = re_x[DATA_W] ? -re_x : re_x;
      abs_im  = im_x[DATA_W] ? -im_x : im_x;
      mag_max = (abs_re > abs_im) ? abs_re : abs_im;
      mag_min = (abs_re > abs_im) ? abs_im : abs_re;
      mag_sum = mag_max + (mag_min >> 1);
      m_mag   = mag_sum[DATA_W-1:0];
   end

endmodule

// File: tb/tb_fft8_bin_unloader.sv
// Directed bench for fft8_bin_unloader: expected beats are queued when frames are
// issued and a negedge monitor pops and compares every accepted beat.
module tb_fft8_bin_unloader;
   localparam int W  = 16;
   localparam int DW = 8;
   localparam int EW = 3*W + 4;

   logic            clk = 1'b0;
   logic            rst_n;
   logic            in_stb;
   logic [8*W-1:0]  in_real, in_imag;
   logic            m_valid, m_ready;
   logic [W-1:0]    m_real, m_imag, m_mag;
   logic [2:0]      m_index;
   logic            m_last, ovf, clr_ovf;
   logic [DW-1:0]   drop_cnt;

   logic [EW-1:0]   exp_q[$];
   int              checks = 0;
   int              errors = 0;

   always #5 clk = ~clk;

   fft8_bin_unloader #(.DATA_W(W), .DROP_W(DW)) dut (
      .clk(clk), .rst(rst_n), .in_stb(in_stb), .in_real(in_real), .in_imag(in_imag),
      .m_valid(m_valid), .m_ready(m_ready), .m_real(m_real), .m_imag(m_imag),
      .m_mag(m_mag), .m_index(m_index), .m_last(m_last), .ovf(ovf),
      .clr_ovf(clr_ovf), .drop_cnt(drop_cnt)
   );

   function automatic logic [W-1:0] ref_mag(input logic [W-1:0] re, input logic [W-1:0] im);
      int a, b, mx, mn;
      a = $signed(re);
      b = $signed(im);
      if (a < 0) a = -a;
      if (b < 0) b = -b;
      mx = (a > b) ? a : b;
      mn = (a > b) ? b : a;
      return W'(mx + mn / 2);
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic push_frame(input logic [8*W-1:0] re, input logic [8*W-1:0] im);
      for (int k = 0; k < 8; k++)
         exp_q.push_back({re[k*W +: W], im[k*W +: W], ref_mag(re[k*W +: W], im[k*W +: W]),
                          3'(k), (k == 7)});
   endtask

   // Drives a one-cycle strobe; cap says whether the frame is expected to be kept.
   task automatic strobe(input logic [8*W-1:0] re, input logic [8*W-1:0] im, input bit cap);
      in_real = re;
      in_imag = im;
      in_stb  = 1'b1;
      if (cap) push_frame(re, im);
      cycle();
      in_stb  = 1'b0;
   endtask

   task automatic make_frame(input int base, output logic [8*W-1:0] re, output logic [8*W-1:0] im);
      for (int k = 0; k < 8; k++) begin
         re[k*W +: W] = W'(base + k*37);
         im[k*W +: W] = W'(base*3 - k*101);
      end
   endtask

   task automatic wait_drain(input string name);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 200) begin
         cycle();
         n++;
      end
      check(name, 64'(exp_q.size()), 64'(0));
   endtask

   always @(negedge clk) begin
      logic [EW-1:0] got, want;
      if (rst_n && m_valid && m_ready) begin
         got = {m_real, m_imag, m_mag, m_index, m_last};
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL beat_unexpected actual=%0h required=none", got);
         end else begin
            want = exp_q.pop_front();
            if (got !== want) begin
               errors++;
               $display("FAIL beat actual=%0h required=%0h", got, want);
            end
         end
      end
   end

   initial begin
      #300000;
      errors++;
      $display("FAIL watchdog actual=timeout required=finish");
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   logic [8*W-1:0] ramp_re, ramp_im, fa_re, fa_im, fb_re, fb_im, fc_re, fc_im;
   logic [8*W-1:0] fd_re, fd_im, fe_re, fe_im, ff_re, ff_im, fg_re, fg_im;
   logic [W-1:0]   hold_re, hold_im, hold_mag;
   logic [W-1:0]   ramp_im_tab[8];

   initial begin
      rst_n = 1'b0; in_stb = 1'b0; in_real = '0; in_imag = '0; m_ready = 1'b0; clr_ovf = 1'b0;
      ramp_im_tab = '{16'h0000, 16'h09A8, 16'h0400, 16'h01A8,
                      16'h0000, 16'hFE58, 16'hFC00, 16'hF658};
      for (int k = 0; k < 8; k++) begin
         ramp_re[k*W +: W] = (k == 0) ? 16'h1C00 : 16'hFC00;
         ramp_im[k*W +: W] = ramp_im_tab[k];
      end

      // Reset state
      #2;
      check("rst_valid", 64'(m_valid), 64'(0));
      check("rst_index", 64'(m_index), 64'(0));
      check("rst_last",  64'(m_last),  64'(0));
      check("rst_ovf",   64'(ovf),     64'(0));
      check("rst_drop",  64'(drop_cnt), 64'(0));
      check("rst_real",  64'(m_real),  64'(0));
      check("rst_imag",  64'(m_imag),  64'(0));
      check("rst_mag",   64'(m_mag),   64'(0));
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      cycle();

      // Ramp frame with m_ready held high
      m_ready = 1'b1;
      strobe(ramp_re, ramp_im, 1'b1);
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         check("ramp_valid", 64'(m_valid), 64'(1));
         check("ramp_index", 64'(m_index), 64'(i));
         check("ramp_last",  64'(m_last),  64'(i == 7));
         if (i == 0) begin
            check("bin0_real", 64'(m_real), 64'(16'h1C00));
            check("bin0_imag", 64'(m_imag), 64'(16'h0000));
            check("bin0_mag",  64'(m_mag),  64'(16'h1C00));
         end
         if (i == 1) begin
            check("bin1_real", 64'(m_real), 64'(16'hFC00));
            check("bin1_imag", 64'(m_imag), 64'(16'h09A8));
            check("bin1_mag",  64'(m_mag),  64'(16'h0BA8));
         end
         if (i == 4) begin
            check("bin4_real", 64'(m_real), 64'(16'hFC00));
            check("bin4_imag", 64'(m_imag), 64'(16'h0000));
            check("bin4_mag",  64'(m_mag),  64'(16'h0400));
         end
      end
      @(negedge clk);
      check("ramp_idle", 64'(m_valid), 64'(0));
      cycle();

      // Backpressure at bin 3
      make_frame(16'h0120, fb_re, fb_im);
      strobe(fb_re, fb_im, 1'b1);
      repeat (3) cycle();
      m_ready = 1'b0;
      @(negedge clk);
      hold_re = m_real; hold_im = m_imag; hold_mag = m_mag;
      check("bp_index", 64'(m_index), 64'(3));
      check("bp_real_bin3", 64'(hold_re), 64'(fb_re[3*W +: W]));
      for (int s = 0; s < 5; s++) begin
         cycle();
         @(negedge clk);
         check("bp_hold_index", 64'(m_index), 64'(3));
         check("bp_hold_real",  64'(m_real),  64'(hold_re));
         check("bp_hold_imag",  64'(m_imag),  64'(hold_im));
         check("bp_hold_mag",   64'(m_mag),   64'(hold_mag));
      end
      cycle();
      m_ready = 1'b1;
      wait_drain("bp_drain");

      // Second frame arriving at beat 2 streams with no bubble
      make_frame(16'h0A00, fa_re, fa_im);
      make_frame(-16'sh0300, fb_re, fb_im);
      strobe(fa_re, fa_im, 1'b1);
      cycle();
      cycle();
      strobe(fb_re, fb_im, 1'b1);
      for (int j = 0; j < 13; j++) begin
         @(negedge clk);
         check("pend_valid_run", 64'(m_valid), 64'(1));
         if (j == 5) check("pend_b_bin0", 64'(m_index), 64'(0));
      end
      @(negedge clk);
      check("pend_idle", 64'(m_valid), 64'(0));
      check("pend_ovf", 64'(ovf), 64'(0));
      cycle();

      // Overflow, clear, saturation
      m_ready = 1'b0;
      make_frame(16'h1111, fc_re, fc_im);
      make_frame(16'h2222, fd_re, fd_im);
      make_frame(16'h3333, fe_re, fe_im);
      make_frame(16'h4444, ff_re, ff_im);
      strobe(fc_re, fc_im, 1'b1);
      strobe(fd_re, fd_im, 1'b1);
      strobe(fe_re, fe_im, 1'b0);
      check("drop1_ovf",  64'(ovf), 64'(1));
      check("drop1_cnt",  64'(drop_cnt), 64'(1));
      clr_ovf = 1'b1;
      cycle();
      clr_ovf = 1'b0;
      check("clr_ovf",  64'(ovf), 64'(0));
      check("clr_cnt",  64'(drop_cnt), 64'(0));
      in_real = fe_re; in_imag = fe_im; in_stb = 1'b1;
      repeat (300) cycle();
      in_stb = 1'b0;
      check("sat_cnt", 64'(drop_cnt), 64'(8'hFF));
      check("sat_ovf", 64'(ovf), 64'(1));
      clr_ovf = 1'b1; in_stb = 1'b1;
      cycle();
      in_stb = 1'b0;
      check("clr_vs_drop_ovf", 64'(ovf), 64'(1));
      check("clr_vs_drop_cnt", 64'(drop_cnt), 64'(1));
      cycle();
      clr_ovf = 1'b0;
      check("clr2_ovf", 64'(ovf), 64'(0));
      check("clr2_cnt", 64'(drop_cnt), 64'(0));

      // Strobe on the last beat with the pending slot full
      m_ready = 1'b1;
      repeat (7) cycle();
      check("sim_last_index", 64'(m_index), 64'(7));
      strobe(ff_re, ff_im, 1'b1);
      check("sim_ovf", 64'(ovf), 64'(0));
      check("sim_cnt", 64'(drop_cnt), 64'(0));
      @(negedge clk);
      check("sim_valid", 64'(m_valid), 64'(1));
      check("sim_index", 64'(m_index), 64'(0));
      check("sim_promoted", 64'(m_real), 64'(fd_re[0 +: W]));
      cycle();
      wait_drain("sim_drain");
      @(negedge clk);
      check("sim_idle", 64'(m_valid), 64'(0));
      cycle();

      // Magnitude extremes
      m_ready = 1'b0;
      fg_re = '0; fg_im = '0;
      fg_re[0*W +: W] = 16'h8000; fg_im[0*W +: W] = 16'h0000;
      fg_re[1*W +: W] = 16'h8000; fg_im[1*W +: W] = 16'h8000;
      fg_re[2*W +: W] = 16'h7FFF; fg_im[2*W +: W] = 16'h8000;
      strobe(fg_re, fg_im, 1'b1);
      @(negedge clk);
      check("mag_8000_0", 64'(m_mag), 64'(16'h8000));
      cycle();
      m_ready = 1'b1;
      cycle();
      m_ready = 1'b0;
      @(negedge clk);
      check("mag_8000_8000", 64'(m_mag), 64'(16'hC000));
      cycle();
      m_ready = 1'b1;
      cycle();
      m_ready = 1'b0;
      @(negedge clk);
      check("mag_7fff_8000", 64'(m_mag), 64'(16'hBFFF));
      cycle();
      m_ready = 1'b1;
      wait_drain("mag_drain");

      // Reset mid-stream at beat 5 with the pending slot full
      make_frame(16'h0055, fa_re, fa_im);
      make_frame(16'h0066, fb_re, fb_im);
      make_frame(16'h0777, fc_re, fc_im);
      strobe(fa_re, fa_im, 1'b1);
      strobe(fb_re, fb_im, 1'b1);
      repeat (4) cycle();
      check("mid_index", 64'(m_index), 64'(5));
      rst_n = 1'b0;
      exp_q.delete();
      #1;
      check("mid_rst_valid", 64'(m_valid), 64'(0));
      check("mid_rst_index", 64'(m_index), 64'(0));
      check("mid_rst_real",  64'(m_real),  64'(0));
      repeat (2) cycle();
      rst_n = 1'b1;
      cycle();
      check("post_rst_idle", 64'(m_valid), 64'(0));
      strobe(fc_re, fc_im, 1'b1);
      check("post_rst_bin0", 64'(m_real), 64'(fc_re[0 +: W]));
      wait_drain("post_rst_drain");
      for (int q = 0; q < 3; q++) begin
         @(negedge clk);
         check("post_rst_quiet", 64'(m_valid), 64'(0));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/fft8_bin_unloader.md
Name: fft8_bin_unloader

Overview:
- Receiving end of the fft8 output interface.
- Captures the eight complex bins that fft8 presents in parallel on its out_stb pulse and streams them one bin per beat over a valid/ready interface.
- Each beat also carries an approximate magnitude.
- Holds one pending frame so back-to-back fft8 frames are not lost while the downstream side stalls; drops and counts frames beyond that.

Parameters:
- DATA_W, 16: width of each real/imag component, two's complement Q8.8.
- DROP_W, 8: width of the saturating dropped-frame counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_stb  in  1  one-cycle frame strobe, connects to fft8 out_stb.
- in_real  in  8*DATA_W  bin k real part at bits [k*DATA_W +: DATA_W]; k=0 is fft8 out1.
- in_imag  in  8*DATA_W  bin k imaginary part, same packing.
- m_valid  out  1  output beat valid.
- m_ready  in  1  downstream accept.
- m_real  out  DATA_W  current bin real part.
- m_imag  out  DATA_W  current bin imaginary part.
- m_mag  out  DATA_W  unsigned magnitude approximation.
- m_index  out  3  bin number 0..7.
- m_last  out  1  high on the bin-7 beat.
- ovf  out  1  sticky: a frame was dropped.
- clr_ovf  in  1  synchronous clear of ovf and drop_cnt.
- drop_cnt  out  DROP_W  saturating count of dropped frames.

Behaviour:
- Reset (rst=0, asynchronous): state IDLE, m_valid=0, m_index=0, m_last=0, ovf=0, drop_cnt=0, pending slot empty. m_real, m_imag and m_mag read 0 (buffers cleared).
- Storage: ACTIVE buffer (8 complex words, being streamed) and PENDING buffer (8 complex words plus a valid bit).
- States: IDLE and STREAM.
- IDLE:
  - in_stb=1 → capture in_real/in_imag into ACTIVE, idx=0, go STREAM.
  - m_valid is high the cycle after the in_stb edge (latency 1).
- STREAM:
  - m_valid=1. m_real, m_imag and m_index reflect ACTIVE[idx]; m_last=(idx==7).
  - A beat completes when m_valid && m_ready at a rising edge. Outputs hold stable while m_ready=0.
  - Non-last beat: idx increments.
  - Last beat, PENDING valid: PENDING→ACTIVE, idx=0, stay STREAM, no bubble.
  - Last beat, PENDING empty, in_stb=1 same cycle: in_stb data→ACTIVE, idx=0, stay STREAM.
  - Last beat, otherwise: go IDLE, m_valid=0 next cycle.
- in_stb during STREAM, not coinciding with a last beat:
  - PENDING empty → capture into PENDING.
  - PENDING full → frame dropped: ovf=1, drop_cnt increments and saturates at all-ones.
- in_stb coinciding with a last beat while PENDING is full: the promotion frees PENDING and the new frame is captured into PENDING in the same cycle. No drop.
- Magnitude:
  - a=|re|, b=|im|, computed at DATA_W+1 bits so -32768 gives 32768.
  - m_mag = max(a,b) + (min(a,b)>>1), truncated to DATA_W bits unsigned.
  - Maximum value 49152, which fits 16 bits.
  - Combinational from ACTIVE[idx].
- clr_ovf:
  - Clears ovf and drop_cnt on the next edge.
  - If a drop occurs the same cycle, the drop wins: ovf=1, drop_cnt=1.
- Reset mid-stream: abandons both buffers immediately. No partial frame resumes after reset.
- in_stb is an edge-qualified level. Holding it high for N cycles counts as N frames.

Test Plan:
- Ramp frame, m_ready held 1. Inputs are the fft8 outputs for the 0..7 Q8.8 ramp. Assert in_stb once.
  - Response: 8 consecutive beats, m_index 0..7, m_last only on the eighth beat, m_valid low on the following cycle.
  - Bin 0: real=0x1C00, imag=0, mag=0x1C00.
  - Bin 1: real=0xFC00, imag=0x09A8, mag=0x0BA8.
  - Bin 4: real=0xFC00, imag=0, mag=0x0400.
- Backpressure: m_ready=0 for 5 cycles at bin 3.
  - m_index stays 3 and m_real/m_imag/m_mag stay stable.
  - Stream resumes at bin 4; no beats lost or duplicated.
- Pending frame: second in_stb at beat 2 of frame A.
  - Frame B's bin 0 is on the beat immediately after A's last beat, with no idle cycle.
  - ovf stays 0.
- Overflow: m_ready=0 and three in_stb pulses.
  - The third pulse sets ovf=1 and drop_cnt=1.
  - clr_ovf then returns both to 0.
  - 300 further drops saturate drop_cnt at 0xFF.
- Simultaneous events:
  - in_stb on the cycle of the last beat with PENDING full → no drop, and the promoted frame streams next.
  - Magnitude extremes: real=0x8000, imag=0 → m_mag=0x8000. real=0x8000, imag=0x8000 → m_mag=0xC000.
- Reset mid-stream: rst low at beat 5 with PENDING full.
  - m_valid drops asynchronously.
  - After release the block is IDLE; a new in_stb streams from bin 0 with the new data only.
